eu_issue_fifo: RTL and testbench
================================

# eu_issue_fifo

Parametrised issue-to-execute buffer for a single pipeline way. It holds the packed micro-op fields (rd address, write enable, PC, operands, immediate, opcode, funct fields, shamt, pID) as one payload word in a DEPTH-entry first-word-fall-through FIFO. It replaces per-field buffers with one storage array, a valid/ready handshake on both sides, occupancy reporting and a pipeline flush. It sits between the issue stage and the execution unit of each way.

## Interface
- DATA_W, 255: payload width in bits (default = packed way0 issue fields: 5+1+32+64+64+64+7+3+7+6+2).
- DEPTH, 4: number of entries; power of two, ≥ 2.
- AF_MARGIN, 1: almost_full_o asserts when count_o ≥ DEPTH − AF_MARGIN; 0 ≤ AF_MARGIN < DEPTH.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  jump/redirect flush; discards all entries.
- valid_i  in  1  upstream has a payload.
- data_i  in  DATA_W  upstream payload.
- ready_o  out  1  FIFO can accept; = (count_o != DEPTH).
- valid_o  out  1  head entry present; = (count_o != 0).
- data_o  out  DATA_W  head payload; all zeros when valid_o = 0.
- ready_i  in  1  execution unit consumes head.
- count_o  out  $clog2(DEPTH+1)  current occupancy 0..DEPTH.
- almost_full_o  out  1  occupancy threshold flag for issue back-pressure.

## Operation
- Storage: DEPTH × DATA_W array; write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits, wrap modulo DEPTH naturally. Separate count register, 0..DEPTH.
- push = valid_i & ready_o & ~flush_i; pop = valid_o & ready_i & ~flush_i.
- push: mem[wptr] ← data_i, wptr ← wptr+1. pop: rptr ← rptr+1.
- count next: +1 on push only, −1 on pop only, unchanged on both or neither.
- ready_o, valid_o, almost_full_o are decoded from the registered count only; none depends combinationally on valid_i or ready_i. A full FIFO therefore rejects a push even when ready_i pops the same cycle.
- data_o = mem[rptr] gated by valid_o (zero when empty), so verification can check for zeros.
- flush_i (priority over push/pop): next cycle wptr = rptr = 0, count = 0. Payload in the array is not cleared. An input beat offered during the flush cycle is dropped.
- reset (priority over flush): wptr = rptr = count = 0. Array contents need not be reset.
- No empty bypass: data written into an empty FIFO becomes visible one cycle later.

## Timing
- Reset values: ready_o = 1, valid_o = 0, data_o = 0, count_o = 0, almost_full_o = 0 (for AF_MARGIN < DEPTH).
- Latency: push at edge N → valid_o and data_o valid after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Handshake: a beat transfers on a rising edge where valid & ready are both high. Upstream holds data_i stable while valid_i & ~ready_o. The FIFO holds data_o stable while valid_o & ~ready_i.
- Flush: at the edge where flush_i = 1, state clears. The following cycle shows valid_o = 0, count_o = 0, ready_o = 1.
- Reset asserted mid-stream: all in-flight entries are lost. Outputs return to reset values in the cycle after the reset edge.
- Pointer wrap: after DEPTH pushes, wptr returns to 0. FIFO order is preserved across the wrap.

## Test plan
- Reset/idle: assert reset 2 cycles with valid_i = 1 → ready_o = 1, valid_o = 0, data_o = 0, count_o = 0. No write is accepted during reset.
- Fill/drain (DEPTH = 4, AF_MARGIN = 1): push 0x11, 0x22, 0x33, 0x44 with ready_i = 0 → count_o goes 1, 2, 3, 4; almost_full_o rises when count = 3; ready_o = 0 at 4. Fifth beat 0x55 is held, not written. Then ready_i = 1 → data_o reads 0x11, 0x22, 0x33, 0x44, and 0x55 is accepted on the cycle after count drops to 3.
- Full + simultaneous pop: at count 4, valid_i = 1 and ready_i = 1 → pop only, count 3. The next cycle push + pop keeps count 3.
- Wrap-around: stream 20 incrementing beats with random ready_i (50%) → output sequence 0..19 is exact, with no loss or duplication, and count_o never exceeds 4.
- Flush: with 3 entries and valid_i = 1 in the flush cycle → next cycle count_o = 0, valid_o = 0, data_o = 0. The flush-cycle beat is absent. A new push of 0xAA then appears as the first output.
- Empty push/pop: on an empty FIFO, push 0x77 with ready_i = 1 → no output in the same cycle. valid_o = 1 with data 0x77 in the next cycle, popped at that edge, then count 0.

Source files
------------

// File: rtl/eu_issue_fifo.sv
// Issue-to-execute buffer for one pipeline way.
// Holds each packed micro-op as a single DATA_W payload in a DEPTH-entry
// first-word-fall-through FIFO with valid/ready on both sides, occupancy
// reporting, an almost-full flag for issue back-pressure and a flush.
//
// Ports:
//   clk           : single clock, all state updates on posedge
//   reset         : synchronous active-high reset (priority over flush)
//   flush_i       : redirect flush, discards every entry and any input beat
//   valid_i       : upstream payload present
//   data_i        : upstream payload
//   ready_o       : FIFO can accept (count != DEPTH)
//   valid_o       : head entry present (count != 0)
//   data_o        : head payload, zero when valid_o is low
//   ready_i       : execution unit consumes the head
//   count_o       : occupancy 0..DEPTH
//   almost_full_o : count >= DEPTH - AF_MARGIN
module eu_issue_fifo #(
  parameter int unsigned DATA_W    = 255,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_MARGIN = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         valid_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [DATA_W-1:0]            data_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);

  // Storage and pointers
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;

  // Status flags kept as registers, loaded from the next occupancy so they
  // always equal a decode of the registered count without any path from
  // valid_i / ready_i.
  logic              r_ready;
  logic              r_valid;
  logic              r_af;

  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_wptr_nxt;
  logic [PTR_W-1:0]  w_rptr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // Handshake qualification; a flush cycle transfers nothing on either side.
  assign w_push = valid_i & r_ready & ~flush_i;
  assign w_pop  = r_valid & ready_i & ~flush_i;

  // Next pointer / occupancy state
  always_comb begin
    w_wptr_nxt = r_wptr;
    w_rptr_nxt = r_rptr;
    w_cnt_nxt  = r_cnt;
    if (flush_i) begin
      w_wptr_nxt = '0;
      w_rptr_nxt = '0;
      w_cnt_nxt  = '0;
    end else begin
      if (w_push) begin
        w_wptr_nxt = r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rptr_nxt = r_rptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
        2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_af    <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != FULL_CNT);
      r_valid <= (w_cnt_nxt != '0);
      r_af    <= (w_cnt_nxt >= AF_CNT);
    end
  end

  // Payload array; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // Head is gated to zero when empty so stale array contents never leak out.
  assign data_o        = r_valid ? r_mem[r_rptr] : '0;
  assign ready_o       = r_ready;
  assign valid_o       = r_valid;
  assign count_o       = r_cnt;
  assign almost_full_o = r_af;

endmodule

// File: tb/tb_eu_issue_fifo.sv
// Directed bench for eu_issue_fifo at DEPTH=4, AF_MARGIN=1, DATA_W=255.
module tb_eu_issue_fifo;

  localparam int unsigned DW = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ready_i;
  logic [2:0]    count_o;
  logic          almost_full_o;

  int total = 0;
  int bad   = 0;

  eu_issue_fifo #(.DATA_W(DW), .DEPTH(4), .AF_MARGIN(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .ready_i       (ready_i),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input int cnt, input logic vld, input logic rdy,
                             input logic af, input logic [255:0] head);
    check_eq({tag, "_cnt"},  256'(count_o), 256'(cnt));
    check_eq({tag, "_vld"},  256'(valid_o), 256'(vld));
    check_eq({tag, "_rdy"},  256'(ready_o), 256'(rdy));
    check_eq({tag, "_af"},   256'(almost_full_o), 256'(af));
    check_eq({tag, "_data"}, 256'(data_o), head);
  endtask

  initial begin
    int sent;
    int recv;
    int mcnt;
    int cyc;
    logic push;
    logic pop;

    reset   = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b1;
    data_i  = DW'(32'hDEAD);
    ready_i = 1'b0;

    // Reset held two cycles with an offered beat
    tick();
    check_state("rst1", 0, 1'b0, 1'b1, 1'b0, 256'h0);
    tick();
    check_state("rst2", 0, 1'b0, 1'b1, 1'b0, 256'h0);
    reset   = 1'b0;
    valid_i = 1'b0;
    tick();
    check_state("idle", 0, 1'b0, 1'b1, 1'b0, 256'h0);

    // Fill with ready_i low
    valid_i = 1'b1;
    data_i = DW'(8'h11); tick(); check_state("f1", 1, 1'b1, 1'b1, 1'b0, 256'h11);
    data_i = DW'(8'h22); tick(); check_state("f2", 2, 1'b1, 1'b1, 1'b0, 256'h11);
    data_i = DW'(8'h33); tick(); check_state("f3", 3, 1'b1, 1'b1, 1'b1, 256'h11);
    data_i = DW'(8'h44); tick(); check_state("f4", 4, 1'b1, 1'b0, 1'b1, 256'h11);
    data_i = DW'(8'h55); tick(); check_state("held", 4, 1'b1, 1'b0, 1'b1, 256'h11);

    // Full with pop: pop only, then push+pop steady at 3
    ready_i = 1'b1;
    tick(); check_state("fullpop", 3, 1'b1, 1'b1, 1'b1, 256'h22);
    tick(); check_state("pushpop", 3, 1'b1, 1'b1, 1'b1, 256'h33);
    valid_i = 1'b0;
    tick(); check_state("d1", 2, 1'b1, 1'b1, 1'b0, 256'h44);
    tick(); check_state("d2", 1, 1'b1, 1'b1, 1'b0, 256'h55);
    tick(); check_state("d3", 0, 1'b0, 1'b1, 1'b0, 256'h0);

    // Wrap-around stream with random consumer
    sent = 0; recv = 0; mcnt = 0; cyc = 0;
    while (recv < 20 && cyc < 500) begin
      valid_i = (sent < 20);
      data_i  = DW'(sent);
      ready_i = 1'($urandom_range(0, 1));
      push = valid_i && ready_o;
      pop  = valid_o && ready_i;
      if (pop) begin
        check_eq("wrap_data", 256'(data_o), 256'(recv));
        recv++;
      end
      if (push) sent++;
      tick();
      mcnt = mcnt + int'(push) - int'(pop);
      check_eq("wrap_cnt", 256'(count_o), 256'(mcnt));
      check_eq("wrap_max", 256'(count_o <= 3'd4), 256'(1));
      cyc++;
    end
    check_eq("wrap_recv", 256'(recv), 256'(20));
    valid_i = 1'b0;
    ready_i = 1'b0;
    tick();
    check_state("wrap_end", 0, 1'b0, 1'b1, 1'b0, 256'h0);

    // Reset mid-stream drops entries
    valid_i = 1'b1;
    data_i = DW'(8'h01); tick();
    data_i = DW'(8'h02); tick();
    check_eq("mid_pre", 256'(count_o), 256'(2));
    reset = 1'b1; valid_i = 1'b0;
    tick();
    reset = 1'b0;
    check_state("midrst", 0, 1'b0, 1'b1, 1'b0, 256'h0);

    // Flush with a beat offered in the flush cycle
    valid_i = 1'b1;
    data_i = DW'(8'hA1); tick();
    data_i = DW'(8'hA2); tick();
    data_i = DW'(8'hA3); tick();
    check_eq("fl_pre", 256'(count_o), 256'(3));
    flush_i = 1'b1; data_i = DW'(8'hBB);
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    check_state("flush", 0, 1'b0, 1'b1, 1'b0, 256'h0);
    valid_i = 1'b1; data_i = DW'(8'hAA);
    tick();
    valid_i = 1'b0;
    check_state("postfl", 1, 1'b1, 1'b1, 1'b0, 256'hAA);
    ready_i = 1'b1;
    tick();
    check_state("postfl_pop", 0, 1'b0, 1'b1, 1'b0, 256'h0);

    // Empty push with consumer ready: no bypass
    valid_i = 1'b1; data_i = DW'(8'h77);
    check_eq("e_novld", 256'(valid_o), 256'(0));
    tick();
    valid_i = 1'b0;
    check_state("e_show", 1, 1'b1, 1'b1, 1'b0, 256'h77);
    tick();
    check_state("e_pop", 0, 1'b0, 1'b1, 1'b0, 256'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
